// File: rtl/jpeg_stream_packer.sv
// jpeg_stream_packer
//   Packs a byte-serial JPEG file stream into 32-bit words with byte strobes
//   for the decoder core input port. The first byte of a word lands in lane 0
//   (data[7:0]). A word closes when lane 3 is written or the input marks the
//   last byte. It can also close when the optional flush timer expires on a
//   stalled partial word.
//
//   Storage is one assembly register plus one output register. A completed
//   word that cannot move to the output is held in the assembly register, and
//   input is blocked until the output frees up.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   inport_valid_i      input byte valid
//   inport_data_i       input byte
//   inport_last_i       final byte of the stream
//   inport_accept_o     byte taken this cycle when valid & accept
//   outport_valid_o     output word valid
//   outport_data_o      packed word, lane 0 = first byte
//   outport_strb_o      byte-lane enables
//   outport_last_o      final word of the stream
//   outport_accept_i    downstream accept
//   byte_count_o        running count of accepted bytes (wraps)
//   idle_o              no partial, held or pending output data
//
// Parameter
//   FLUSH_CYCLES        idle input cycles before a partial word is pushed out
//                       with last=0; 0 disables flushing

module jpeg_stream_packer #(
    parameter int FLUSH_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_valid_i,
    input  logic [7:0]  inport_data_i,
    input  logic        inport_last_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    output logic [3:0]  outport_strb_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    output logic [31:0] byte_count_o,
    output logic        idle_o
);

    logic [31:0] asm_data;
    logic [3:0]  asm_strb;
    logic [1:0]  fill;
    logic        asm_last;
    logic        complete;

    logic        out_free;
    logic        byte_acc;
    logic        held_xfer;
    logic        byte_done;
    logic        word_done;
    logic        flush_fire;
    logic [31:0] new_data;
    logic [3:0]  new_strb;
    logic        new_last;

    always_comb begin
        out_free        = !outport_valid_o | outport_accept_i;
        inport_accept_o = !complete | out_free;
        byte_acc        = inport_valid_i & inport_accept_o;
        held_xfer       = complete & out_free;

        // A held word leaves this cycle, so a new byte builds on an empty
        // assembly. fill is already 0 whenever complete=1.
        new_data = held_xfer ? 32'h0 : asm_data;
        new_strb = held_xfer ? 4'h0  : asm_strb;
        if (byte_acc) begin
            new_data[{fill, 3'b000} +: 8] = inport_data_i;
            new_strb[fill]                = 1'b1;
        end
        new_last  = byte_acc & inport_last_i;
        byte_done = byte_acc & ((fill == 2'd3) | inport_last_i);
        word_done = byte_done | flush_fire;
    end

    generate
        if (FLUSH_CYCLES > 0) begin : g_flush
            localparam int TW = $clog2(FLUSH_CYCLES + 1);
            logic [TW-1:0] flush_timer;
            logic          flush_count;

            assign flush_count = (fill != 2'd0) & !complete & !byte_acc;
            // Fires in the idle cycle that brings the count to FLUSH_CYCLES.
            assign flush_fire  = flush_count & (flush_timer == TW'(FLUSH_CYCLES - 1));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    flush_timer <= '0;
                end else if (!flush_count || flush_fire) begin
                    flush_timer <= '0;
                end else begin
                    flush_timer <= flush_timer + TW'(1);
                end
            end
        end else begin : g_no_flush
            assign flush_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_data        <= 32'h0;
            asm_strb        <= 4'h0;
            asm_last        <= 1'b0;
            fill            <= 2'd0;
            complete        <= 1'b0;
            outport_valid_o <= 1'b0;
            outport_data_o  <= 32'h0;
            outport_strb_o  <= 4'h0;
            outport_last_o  <= 1'b0;
            byte_count_o    <= 32'h0;
        end else begin
            if (byte_acc) begin
                byte_count_o <= byte_count_o + 32'd1;
            end

            // Output register: a held word has priority over a newly
            // completed one, because it is older.
            if (held_xfer) begin
                outport_valid_o <= 1'b1;
                outport_data_o  <= asm_data;
                outport_strb_o  <= asm_strb;
                outport_last_o  <= asm_last;
            end else if (word_done && out_free) begin
                outport_valid_o <= 1'b1;
                outport_data_o  <= new_data;
                outport_strb_o  <= new_strb;
                outport_last_o  <= new_last;
            end else if (outport_accept_i) begin
                outport_valid_o <= 1'b0;
            end

            // Assembly register
            if (word_done) begin
                if (out_free && !held_xfer) begin
                    asm_data <= 32'h0;
                    asm_strb <= 4'h0;
                    asm_last <= 1'b0;
                    complete <= 1'b0;
                end else begin
                    asm_data <= new_data;
                    asm_strb <= new_strb;
                    asm_last <= new_last;
                    complete <= 1'b1;
                end
                fill <= 2'd0;
            end else if (held_xfer || byte_acc) begin
                asm_data <= new_data;
                asm_strb <= new_strb;
                asm_last <= 1'b0;
                complete <= 1'b0;
                fill     <= byte_acc ? fill + 2'd1 : 2'd0;
            end
        end
    end

    assign idle_o = (fill == 2'd0) & !complete & !outport_valid_o;

endmodule
